hilo_muldiv: RTL

Multi-cycle multiply/divide unit owning the HI/LO register pair. It produces the `hodata`, `lodata` and `mulz` values that the register file selects on MFHI, MFLO and MUL write-back. It sits beside the ALU in the execute stage. While an operation runs, it raises `busy` so the control unit stalls any dependent MFHI, MFLO or MUL.

---
 rtl/hilo_muldiv.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative radix-2 multiply/divide unit that owns HI, LO and the MUL result register.
// Define HILO_MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU are one-cycle no-ops.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             MD_CLK,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hodata,
  output logic [WIDTH-1:0] lodata,
  output logic [WIDTH-1:0] mulz
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MUL   = 3'b110,
    OP_NOP   = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  op_e                op_in;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mulz_q, mulz_d;
  logic               done_q, done_d;

  logic               signed_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

  assign op_in     = op_e'(op);
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_MUL) || (op_in == OP_DIV);
  assign mag_a     = (signed_in && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_in && b[WIDTH-1]) ? -b : b;

  // Multiplier bits sit in the low half of acc and are consumed LSB first while the product grows from the top.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;

`ifdef HILO_MULDIV_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             divzero_q, divzero_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             div_ge;
  logic             is_div_q;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // The shifted partial remainder is WIDTH+1 bits; after a successful subtract it always fits back in WIDTH.
  assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, opb_q};
  assign div_ge   = ~diff[WIDTH+1];
  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_q : rem_q;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mulz_d  = mulz_q;
    done_d  = 1'b0;
`ifdef HILO_MULDIV_DIV_EN
    rem_d     = rem_q;
    a_d       = a_q;
    divzero_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_in)
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
`ifdef HILO_MULDIV_DIV_EN
            OP_MULT, OP_MULTU, OP_MUL, OP_DIV, OP_DIVU: begin
              rem_d = '0;
              a_d   = a;
`else
            OP_MULT, OP_MULTU, OP_MUL: begin
`endif
              state_d = S_CALC;
              op_d    = op_in;
              cnt_d   = '0;
              sa_d    = signed_in & a[WIDTH-1];
              sb_d    = signed_in & b[WIDTH-1];
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              opb_d   = mag_b;
            end
            default: done_d = 1'b1;
          endcase
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef HILO_MULDIV_DIV_EN
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          rem_d = div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        end else begin
          acc_d = mul_next;
        end
`else
        acc_d = mul_next;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MUL: mulz_d = prod_fix[WIDTH-1:0];
          OP_MULT, OP_MULTU: begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
`ifdef HILO_MULDIV_DIV_EN
          OP_DIV, OP_DIVU: begin
            if (opb_q == '0) begin
              hi_d      = a_q;
              lo_d      = '1;
              divzero_d = 1'b1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
`endif
          default: ;
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
  always_ff @(posedge MD_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mulz_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mulz_q  <= mulz_d;
      done_q  <= done_d;
    end
  end

`ifdef HILO_MULDIV_DIV_EN
  always_ff @(posedge MD_CLK or negedge resetn) begin
    if (!resetn) begin
      rem_q     <= '0;
      a_q       <= '0;
      divzero_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      a_q       <= a_d;
      divzero_q <= divzero_d;
    end
  end

  assign divzero = divzero_q;
`else
  assign divzero = 1'b0;
`endif

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hodata = hi_q;
  assign lodata = lo_q;
  assign mulz   = mulz_q;

endmodule
